div_unit: RTL
=============

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the Execute stage. Implements MIPS DIV and DIVU.
- It is the requesting side of the hazard/stall protocol. It raises a stall request to the hazard unit while a divide is in flight.
- On completion it presents {HI = remainder, LO = quotient} for the HILO write path.
- Pipeline flushes use the annul input to cancel an in-flight operation.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
- clk  input  1  clock; all state on the rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request from Execute: divide instruction present (held high while the instruction sits in E)
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU
- dividend  input  WIDTH  rs operand after forwarding
- divisor  input  WIDTH  rt operand after forwarding
- annul  input  1  cancel the in-flight divide (flush/exception)
- stall_req  output  1  to the hazard unit: hold F/D/E, bubble M
- ready  output  1  one-cycle pulse: result valid
- result  output  2*WIDTH  {remainder, quotient}; HI = result[2W-1:W], LO = result[W-1:0]

Behaviour:
- Reset: state=FREE, count=0, result=0, ready=0, stall_req=0; any operation in flight is discarded.
- States: FREE, BY_ZERO, ON, END.
- FREE, start=1, annul=0:
  - Latch the operands.
  - If divisor==0, go to BY_ZERO; otherwise go to ON with count=0.
  - If signed_div: latch |dividend| and |divisor|; record neg_q = sign(dividend)^sign(divisor) and neg_r = sign(dividend).
  - Operand changes after this cycle are ignored.
- ON: one shift-subtract iteration per cycle.
  - Partial remainder {r, q} shifts left 1 and trial-subtracts the divisor; if r >= divisor then q LSB = 1.
  - count increments each cycle. After WIDTH iterations (count==WIDTH-1) go to END.
  - Entering END, apply signs: quotient negated if neg_q, remainder negated if neg_r. Load result.
- BY_ZERO: result <= {dividend_latched, all-ones}; go to END. MIPS leaves this undefined; this value is the team-fixed one.
- END: ready=1 for exactly this cycle, then FREE unconditionally.
  - Upstream advances on this cycle, so start for the finished instruction must be low or belong to a new instruction by the next cycle.
- result holds its value until the next END load; it is meaningful only when ready=1.
- stall_req, combinational:
  - high when (state==FREE & start & ~annul), or state==ON, or state==BY_ZERO;
  - low in END and whenever annul=1.
- Latency, with start first sampled in cycle 0:
  - normal divide: ON in cycles 1..WIDTH, END/ready in cycle WIDTH+1 (33 for WIDTH=32);
  - divide by zero: ready in cycle 2.
- annul=1 in any state: next state FREE, ready stays 0, result unchanged. annul wins over start in the same cycle.
- Signed overflow: 0x80000000 / -1 gives quotient 0x80000000 and remainder 0 (wrap, no trap).
- Unsigned mode uses raw operands with no sign correction. 0/x gives {0, 0}.
- Back-to-back: start high in the cycle after END begins a new divide with the same latency.

Test Plan:
- DIVU 100/7, start cycle 0 -> stall_req=1 in cycles 0..32; ready=1 only in cycle 33; result={32'd2, 32'd14}.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 7/-2 -> LO=0xFFFFFFFD, HI=0x00000001. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5/0 -> ready in cycle 2; result={32'd5, 32'hFFFFFFFF}; stall_req high cycles 0..1.
- Start 1000/3, annul in cycle 10 -> stall_req=0 in cycle 10, state FREE in cycle 11, no ready pulse, result keeps its prior value; a new start in cycle 11 completes normally in cycle 44.
- Assert rst asynchronously mid-ON (cycle 15, between edges) -> stall_req, ready and result go to 0 immediately; after release, DIVU 9/3 gives {0, 3} at +33.
- Back-to-back DIVU 20/6 then 0xFFFFFFFF/0x10 -> ready cycles 33 and 67; results {2, 3} and {0xF, 0x0FFFFFFF}; stall_req low only in cycle 33 between them.

Source files
------------

// File: rtl/div_unit_if.sv
// Execute-stage divider bus: operands and controls from Execute, stall and result back.
// start is held while the divide sits in E; ready pulses once with result; stall_req holds F/D/E meanwhile.
interface div_unit_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic                 signed_div;
   logic [WIDTH-1:0]     dividend;
   logic [WIDTH-1:0]     divisor;
   logic                 annul;
   logic                 stall_req;
   logic                 ready;
   logic [2*WIDTH-1:0]   result;

   modport master (
      output start, signed_div, dividend, divisor, annul,
      input  stall_req, ready, result
   );

   modport slave (
      input  start, signed_div, dividend, divisor, annul,
      output stall_req, ready, result
   );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU; one quotient bit per cycle.
// Result layout is {remainder (HI), quotient (LO)}; divide by zero yields {dividend, all-ones}.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   div_unit_if.slave   bus,
   output logic [1:0]  dbgState
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      FREE    = 2'd0,
      BY_ZERO = 2'd1,
      ON      = 2'd2,
      END     = 2'd3
   } divState_e;

   divState_e state, nextState;

   logic [CW-1:0]      count;
   logic [WIDTH-1:0]   remReg, quoReg, divReg;
   logic               negQ, negR;
   logic [2*WIDTH-1:0] resultReg;

   logic               accept, lastIter;
   logic [WIDTH-1:0]   absDividend, absDivisor;
   logic [WIDTH:0]     shifted, trial;
   logic               fits;
   logic [WIDTH-1:0]   nextRem, nextQuo, finalRem, finalQuo;

   assign accept   = bus.start & ~bus.annul;
   assign lastIter = (count == CW'(WIDTH - 1));

   // In signed mode the magnitudes are divided and signs reapplied on the way out.
   assign absDividend = (bus.signed_div && bus.dividend[WIDTH-1]) ?
                        (WIDTH'(0) - bus.dividend) : bus.dividend;
   assign absDivisor  = (bus.signed_div && bus.divisor[WIDTH-1]) ?
                        (WIDTH'(0) - bus.divisor) : bus.divisor;

   assign shifted  = {remReg, quoReg[WIDTH-1]};
   assign trial    = shifted - {1'b0, divReg};
   assign fits     = ~trial[WIDTH];
   assign nextRem  = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign nextQuo  = {quoReg[WIDTH-2:0], fits};
   assign finalRem = negR ? (WIDTH'(0) - nextRem) : nextRem;
   assign finalQuo = negQ ? (WIDTH'(0) - nextQuo) : nextQuo;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FREE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         FREE:    if (accept) nextState = (bus.divisor == '0) ? BY_ZERO : ON;
         ON:      if (lastIter) nextState = END;
         BY_ZERO: nextState = END;
         END:     nextState = FREE;
         default: nextState = FREE;
      endcase
      if (bus.annul) nextState = FREE;
   end

   // Reset gates the stall combinationally so the pipeline is released the moment rst rises.
   always_comb begin
      bus.stall_req = 1'b0;
      bus.ready     = 1'b0;
      if (!rst && !bus.annul) begin
         bus.stall_req = ((state == FREE) && bus.start) || (state == ON) || (state == BY_ZERO);
         bus.ready     = (state == END);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= '0;
         remReg    <= '0;
         quoReg    <= '0;
         divReg    <= '0;
         negQ      <= 1'b0;
         negR      <= 1'b0;
         resultReg <= '0;
      end else if (!bus.annul) begin
         case (state)
            FREE: if (bus.start) begin
               count  <= '0;
               remReg <= '0;
               quoReg <= absDividend;
               divReg <= absDivisor;
               negQ   <= bus.signed_div & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
               negR   <= bus.signed_div & bus.dividend[WIDTH-1];
            end
            ON: begin
               remReg <= nextRem;
               quoReg <= nextQuo;
               count  <= count + CW'(1);
               if (lastIter) resultReg <= {finalRem, finalQuo};
            end
            BY_ZERO: resultReg <= {quoReg, {WIDTH{1'b1}}};
            default: ;
         endcase
      end
   end

   assign bus.result = resultReg;
   assign dbgState   = state;
endmodule
